// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and byte-lane helpers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // IDLE: no data phase pending, or the completing cycle of one.
  // WAIT: inserting wait states. ERR1: first cycle of the ERROR response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2
  } slave_state_e;

  // Little-endian byte enables for a transfer of the given size at addr_lo.
  function automatic logic [3:0] byte_enable(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  // Unsupported size, or a half/word transfer not aligned to its size.
  function automatic logic transfer_illegal(input logic [2:0] size,
                                            input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr_lo[0];
      HSIZE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_byte_ram.sv
// DEPTH x 32 word memory: asynchronous read, byte-enable synchronous write,
// asynchronous clear of every word on reset.
module ahb_byte_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Clear on reset; otherwise update only the enabled byte lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave with configurable wait states and a two-cycle ERROR.
//
// Handshake: an address phase is taken on a rising edge where
// hsel & hready_in & htrans[1]. Its data phase ends in the first cycle with
// hreadyout=1 (the completing cycle); read data is valid only there and a
// write commits on the edge that ends it. A new address phase may be taken
// in that same completing cycle, so transfers pipeline with no idle gap.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready_in,
  output logic [31:0]       hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output slave_state_e      dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  slave_state_e  state, state_nx;
  logic [2:0]    wait_cnt, wait_cnt_nx;

  logic          cap_valid;
  logic [AW-1:0] cap_off;
  logic          cap_write;
  logic          cap_err;
  logic [3:0]    cap_be;

  logic          accept;
  logic          addr_err;
  logic          ready_cycle;
  logic          complete;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic          unused_bits;

  assign accept      = hsel & hready_in & htrans[1];
  assign addr_err    = transfer_illegal(hsize, haddr[1:0]);
  assign ready_cycle = (state == IDLE);
  assign complete    = ready_cycle & cap_valid;
  assign ram_we      = complete & cap_write & ~cap_err;
  assign unused_bits = ^{haddr[ADDR_W-1:AW+2], htrans[0]};

  // Next-state and wait-count logic.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (addr_err) begin
            state_nx = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nx    = WAIT;
            wait_cnt_nx = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 3'd0) begin
          state_nx = IDLE;
        end else begin
          wait_cnt_nx = wait_cnt - 3'd1;
        end
      end
      ERR1:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Address-phase capture; only ready cycles can end or start a data phase.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cap_valid <= 1'b0;
      cap_off   <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_be    <= 4'b0000;
    end else if (ready_cycle) begin
      cap_valid <= accept;
      if (accept) begin
        cap_off   <= haddr[AW+1:2];
        cap_write <= hwrite;
        cap_err   <= addr_err;
        cap_be    <= byte_enable(hsize, haddr[1:0]);
      end
    end
  end

  ahb_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (hclk),
    .rst   (hreset),
    .we    (ram_we),
    .be    (cap_be),
    .addr  (cap_off),
    .wdata (hwdata),
    .rdata (ram_rdata)
  );

  assign hreadyout = ready_cycle;
  assign hresp     = (state == ERR1) | (complete & cap_err);
  assign hrdata    = (complete & ~cap_write & ~cap_err) ? ram_rdata : 32'h0;
  assign dbg_state = state;

endmodule
